// File: rtl/gmii_tx_arbiter.sv
// Two-source GMII transmit arbiter: round-robin grant, preamble/SFD insertion,
// byte streaming with inter-frame gap, length limit and underrun abort.
module gmii_tx_arbiter #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12,
    parameter int MAX_BYTES    = 1522
) (
    input  logic        gmii_tx_clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  src_valid,
    input  logic [1:0]  src_last,
    input  logic [15:0] src_data,
    output logic [1:0]  gnt,
    output logic [1:0]  src_ready,
    output logic [7:0]  gmii_tx_data,
    output logic        gmii_tx_en,
    output logic        busy,
    output logic        frame_done,
    output logic        err_underrun,
    output logic        err_oversize
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IFG} state_t;

    localparam int CW = 11;
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 2);
    localparam logic [CW-1:0] MAX_LAST = CW'(MAX_BYTES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          ptr_q, ptr_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rdy_q, rdy_d;
    logic [7:0]    data_q, data_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic          und_q, und_d;
    logic          ovs_q, ovs_d;

    logic [7:0]    cur_byte;
    logic          cur_valid;
    logic          cur_last;
    logic          pick;

    assign cur_byte  = sel_q ? src_data[15:8] : src_data[7:0];
    assign cur_valid = src_valid[sel_q];
    assign cur_last  = src_last[sel_q];
    // With both requesting, serve whichever source did not go last.
    assign pick      = (req == 2'b11) ? ~ptr_q : req[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        rdy_d   = rdy_q;
        data_d  = 8'h00;
        en_d    = 1'b0;
        done_d  = 1'b0;
        und_d   = 1'b0;
        ovs_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    sel_d   = pick;
                    ptr_d   = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                end
            end
            PRE: begin
                en_d   = 1'b1;
                data_d = 8'h55;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                end
            end
            SFD: begin
                en_d    = 1'b1;
                data_d  = 8'hD5;
                rdy_d   = gnt_q;
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                if (cur_valid) begin
                    en_d   = 1'b1;
                    data_d = cur_byte;
                    cnt_d  = cnt_q + 1'b1;
                    if (cur_last || (cnt_q == MAX_LAST)) begin
                        state_d = IFG;
                        cnt_d   = '0;
                        gnt_d   = 2'b00;
                        rdy_d   = 2'b00;
                        done_d  = 1'b1;
                        ovs_d   = ~cur_last;
                    end
                end else begin
                    // Underrun: the gap already begins this cycle, so start one count ahead.
                    state_d = IFG;
                    cnt_d   = CW'(1);
                    gnt_d   = 2'b00;
                    rdy_d   = 2'b00;
                    und_d   = 1'b1;
                end
            end
            IFG: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q >= IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            ptr_q   <= 1'b1;
            gnt_q   <= 2'b00;
            rdy_q   <= 2'b00;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            und_q   <= 1'b0;
            ovs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
            und_q   <= und_d;
            ovs_q   <= ovs_d;
        end
    end

    assign gnt          = gnt_q;
    assign src_ready    = rdy_q;
    assign gmii_tx_data = data_q;
    assign gmii_tx_en   = en_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = done_q;
    assign err_underrun = und_q;
    assign err_oversize = ovs_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Bench for gmii_tx_arbiter: per-source frame drivers, a GMII burst monitor and a
// frame-level reference model of arbitration order, truncation and error outcome.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;

    localparam int PRE  = 7;
    localparam int IFG  = 12;
    localparam int MAXB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0, r1, v0, v1, l0, l1;
    logic [7:0] d0, d1;
    logic [1:0] gnt, src_ready;
    logic [7:0] gmii_tx_data;
    logic       gmii_tx_en, busy, frame_done, err_underrun, err_oversize;

    always #5 clk = ~clk;

    gmii_tx_arbiter #(.PREAMBLE_LEN(PRE), .IFG_CYCLES(IFG), .MAX_BYTES(MAXB)) dut (
        .gmii_tx_clk (clk),
        .rst_n       (rst_n),
        .req         ({r1, r0}),
        .src_valid   ({v1, v0}),
        .src_last    ({l1, l0}),
        .src_data    ({d1, d0}),
        .gnt         (gnt),
        .src_ready   (src_ready),
        .gmii_tx_data(gmii_tx_data),
        .gmii_tx_en  (gmii_tx_en),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_underrun(err_underrun),
        .err_oversize(err_oversize)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Frame plans per source
    int         nf   [2];
    int         plen [2][8];
    int         pund [2][8];
    bit         plast[2][8];
    logic [7:0] pdat [2][8][20];

    task automatic set_frame(input int k, input int f, input int len, input int und, input bit last);
        plen[k][f]  = len;
        pund[k][f]  = und;
        plast[k][f] = last;
        for (int i = 0; i < 20; i++) pdat[k][f][i] = 8'($urandom);
    endtask

    // Expected frame as it should appear on GMII
    typedef struct packed {
        logic [1:0]  src;
        logic [3:0]  n;
        logic [63:0] pl;
        logic        done;
        logic        und;
        logic        ovs;
        logic        exact;
    } exp_t;

    exp_t expq[$];
    int   model_last;

    function automatic exp_t model_frame(input int k, input int f, input bit exact);
        exp_t e;
        int   eff;
        e       = '0;
        eff     = (plen[k][f] < MAXB) ? plen[k][f] : MAXB;
        e.src   = 2'(k);
        e.exact = exact;
        e.und   = (pund[k][f] >= 0) && (pund[k][f] < eff);
        e.n     = 4'(e.und ? pund[k][f] : eff);
        e.done  = !e.und;
        e.ovs   = e.done && !(plast[k][f] && plen[k][f] <= MAXB);
        for (int i = 0; i < 8; i++)
            if (i < int'(e.n)) e.pl[8*i +: 8] = pdat[k][f][i];
        return e;
    endfunction

    // Order when every planned frame is already requested: alternate while both
    // sources have work, otherwise serve whoever remains.
    task automatic model_schedule();
        int f0, f1, pick;
        bit first;
        f0 = 0; f1 = 0; first = 1;
        while (f0 < nf[0] || f1 < nf[1]) begin
            if (f0 < nf[0] && f1 < nf[1]) pick = 1 - model_last;
            else pick = (f0 < nf[0]) ? 0 : 1;
            expq.push_back(model_frame(pick, (pick == 1) ? f1 : f0, !first));
            if (pick == 1) f1++; else f0++;
            model_last = pick;
            first = 0;
        end
    endtask

    task automatic set_src(input int k, input logic r, input logic v, input logic l, input logic [7:0] d);
        if (k == 0) begin r0 = r; v0 = v; l0 = l; d0 = d; end
        else        begin r1 = r; v1 = v; l1 = l; d1 = d; end
    endtask

    task automatic drive_src(input int k, input int dly);
        int idx, cyc;
        bit seen, fin;
        repeat (dly) @(negedge clk);
        for (int f = 0; f < nf[k]; f++) begin
            idx = 0; cyc = 0; seen = 0; fin = 0;
            set_src(k, 1'b1, 1'b0, 1'b0, 8'h00);
            while (!fin) begin
                @(negedge clk);
                cyc++;
                if (gnt[k]) seen = 1;
                if ((seen && !gnt[k]) || cyc > 300) begin
                    if (cyc > 300) begin
                        n_tests++; n_fail++;
                        $display("FAIL drv_timeout: src%0d frame %0d still open after %0d cycles, required end", k, f, cyc);
                    end
                    set_src(k, 1'b0, 1'b0, 1'b0, 8'h00);
                    fin = 1;
                end else if (src_ready[k] && idx != pund[k][f] && idx < plen[k][f]) begin
                    set_src(k, 1'b1, 1'b1, plast[k][f] && (idx == plen[k][f] - 1), pdat[k][f][idx]);
                    idx++;
                end else begin
                    set_src(k, 1'b1, 1'b0, 1'b0, 8'h00);
                end
            end
        end
    endtask

    // GMII monitor
    bit   mon_on = 0;
    bit   in_burst = 0;
    int   bi, gap = 1000, cf, cu, co;
    exp_t cur;

    always @(negedge clk) begin
        if (!mon_on) begin
            in_burst = 0;
            gap = 1000;
        end else begin
            check("rdy_outside_gnt", src_ready & ~gnt, 0);
            if (frame_done || err_underrun || err_oversize) begin
                check("pulse_gnt", gnt, 0);
                check("pulse_rdy", src_ready, 0);
            end
            if (err_oversize) check("ovs_with_done", frame_done, 1);
            if (err_underrun) check("und_no_done", frame_done, 0);
            if (gmii_tx_en) begin
                if (!in_burst) begin
                    in_burst = 1; bi = 0; cf = 0; cu = 0; co = 0;
                    check("exp_avail", expq.size() > 0, 1);
                    if (expq.size() > 0) cur = expq.pop_front();
                    else cur = '0;
                    if (gap < 1000) begin
                        if (cur.exact) check("gap_exact", gap, IFG);
                        else check("gap_min", gap >= IFG, 1);
                    end
                    check("gnt_src", gnt, 2'b01 << cur.src);
                end
                if (bi < PRE) begin
                    check("pre_byte", gmii_tx_data, 8'h55);
                    check("pre_rdy", src_ready, 0);
                end else if (bi == PRE) begin
                    check("sfd_byte", gmii_tx_data, 8'hD5);
                    check("sfd_rdy", src_ready, 2'b01 << cur.src);
                end else if (bi - PRE - 1 < int'(cur.n)) begin
                    check("payload", gmii_tx_data, cur.pl[8*(bi-PRE-1) +: 8]);
                end
                bi++;
                cf += int'(frame_done); cu += int'(err_underrun); co += int'(err_oversize);
            end else begin
                check("idle_data", gmii_tx_data, 0);
                if (in_burst) begin
                    cf += int'(frame_done); cu += int'(err_underrun); co += int'(err_oversize);
                    check("payload_len", bi - PRE - 1, cur.n);
                    check("frame_done_cnt", cf, cur.done);
                    check("underrun_cnt", cu, cur.und);
                    check("oversize_cnt", co, cur.ovs);
                    in_burst = 0;
                    gap = 1;
                end else begin
                    check("stray_pulse", {frame_done, err_underrun, err_oversize}, 0);
                    if (gap < 1000) gap++;
                end
            end
        end
    end

    task automatic run_batch(input int dly0, input int dly1);
        fork
            drive_src(0, dly0);
            drive_src(1, dly1);
        join
        repeat (IFG + 5) @(negedge clk);
        check("drained", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        model_last = 1;
        rst_n = 1'b0;
        set_src(0, 1'b0, 1'b0, 1'b0, 8'h00);
        set_src(1, 1'b0, 1'b0, 1'b0, 8'h00);
        nf[0] = 0; nf[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_en", gmii_tx_en, 0);
        check("rst_data", gmii_tx_data, 0);
        check("rst_gnt", gnt, 0);
        check("rst_rdy", src_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_done, err_underrun, err_oversize}, 0);
        rst_n = 1'b1;
        mon_on = 1;

        // Single source, 4 bytes
        nf[0] = 1; nf[1] = 0;
        set_frame(0, 0, 4, -1, 1);
        pdat[0][0][0] = 8'hA1; pdat[0][0][1] = 8'hA2;
        pdat[0][0][2] = 8'hA3; pdat[0][0][3] = 8'hA4;
        model_schedule();
        run_batch(0, 0);

        // Source 1 requests during source 0's frame
        nf[0] = 1; nf[1] = 1;
        set_frame(0, 0, 6, -1, 1);
        set_frame(1, 0, 3, -1, 1);
        expq.push_back(model_frame(0, 0, 1'b0));
        expq.push_back(model_frame(1, 0, 1'b1));
        model_last = 1;
        run_batch(0, 5);

        // Underrun on the third byte, then an immediate follow-up frame
        nf[0] = 2; nf[1] = 0;
        set_frame(0, 0, 5, 2, 1);
        set_frame(0, 1, 3, -1, 1);
        model_schedule();
        run_batch(0, 0);

        // Oversize: 20 bytes offered, no last
        nf[0] = 1; nf[1] = 0;
        set_frame(0, 0, 20, -1, 0);
        model_schedule();
        run_batch(0, 0);

        // Reset mid-payload
        mon_on = 0;
        nf[0] = 1; nf[1] = 0;
        set_frame(0, 0, 8, -1, 1);
        fork
            drive_src(0, 0);
            begin
                w = 0;
                while (!src_ready[0] && w < 50) begin @(negedge clk); w++; end
                check("rst6_reach_data", src_ready[0], 1);
                repeat (2) @(negedge clk);
                check("rst6_busy_before", busy, 1);
                rst_n = 1'b0;
                @(negedge clk);
                check("rst6_en", gmii_tx_en, 0);
                check("rst6_data", gmii_tx_data, 0);
                check("rst6_gnt", gnt, 0);
                check("rst6_rdy", src_ready, 0);
                check("rst6_busy", busy, 0);
                rst_n = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check("rst6_idle", {busy, gmii_tx_en}, 0);
        model_last = 1;
        mon_on = 1;

        // Both requesting, 2-byte frames: 0,1,0,1
        nf[0] = 2; nf[1] = 2;
        for (int f = 0; f < 2; f++) begin
            set_frame(0, f, 2, -1, 1);
            set_frame(1, f, 2, -1, 1);
        end
        model_schedule();
        run_batch(0, 0);

        // Randomized rounds
        for (int round = 0; round < 3; round++) begin
            for (int k = 0; k < 2; k++) begin
                nf[k] = int'($urandom_range(2, 5));
                for (int f = 0; f < nf[k]; f++) begin
                    int len;
                    len = int'($urandom_range(1, 8));
                    if ($urandom_range(0, 3) == 0)
                        set_frame(k, f, len, int'($urandom_range(0, len - 1)), 1);
                    else if ($urandom_range(0, 5) == 0)
                        set_frame(k, f, int'($urandom_range(9, 20)), -1, 0);
                    else
                        set_frame(k, f, len, -1, 1);
                end
            end
            model_schedule();
            run_batch(0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
